modexp_engine: RTL and testbench
================================

Name: modexp_engine

Overview:
- Parametrised modular exponentiator computing base^exponent mod modulus for the ElGamal datapath (key generation, c1 = g^k, shared secret s = y^k).
- Right-to-left square-and-multiply with two bit-serial modular multipliers running in parallel.
- A single AXI-stream job interface carries all operands plus a transaction ID; results return with an error flag.
- Successor to the fixed-width exponentiator: adds full valid/ready handshakes, a separate exponent width, early termination, operand checking and ID passthrough.

Parameters:
- WIDTH, 64, bit width of base, modulus and result (≥4).
- EXP_WIDTH, 64, bit width of exponent (≥1).
- ID_WIDTH, 4, width of transaction tag passed through unchanged (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tdata_base  in  WIDTH  base operand.
- s_tdata_exp  in  EXP_WIDTH  exponent operand.
- s_tdata_mod  in  WIDTH  modulus operand.
- s_tid  in  ID_WIDTH  job tag.
- s_tvalid  in  1  job valid.
- s_tready  out  1  engine ready to accept a job.
- m_tdata  out  WIDTH  result.
- m_tid  out  ID_WIDTH  tag of the job that produced the result.
- m_terr  out  1  operand error; m_tdata is 0 when set.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous assert; release synchronised by upstream): state IDLE, s_tready=0 during reset, m_tvalid=0, m_tdata=0, m_tid=0, m_terr=0, multipliers idle. Reset mid-job discards the job silently.
- States: IDLE, LOAD, RUN, WAIT, OUT.
- IDLE: s_tready=1. Transfer on s_tvalid&s_tready; capture all operands and tag; go to LOAD. s_tready=0 in every other state (one job in flight).
- LOAD (1 cycle): classify the job.
  - modulus==0 or base>=modulus: m_terr=1, result 0, go to OUT.
  - modulus==1: result 0, terr=0, go to OUT.
  - exponent==0: result 1, go to OUT.
  - Otherwise: acc=1, b=base, e=exponent, go to RUN.
- RUN (1 cycle): pulse start on both multipliers: mulA = acc*b mod m, mulB = b*b mod m. Go to WAIT.
- WAIT: both multipliers assert done in the same cycle, exactly WIDTH cycles after start. On done:
  - if e[0]: acc <= mulA result;
  - always: b <= mulB result; e <= e>>1;
  - if (e>>1)==0: result=acc (updated value), go to OUT; else go to RUN.
- OUT: m_tvalid=1; m_tdata, m_tid and m_terr are stable until m_tvalid&m_tready. On transfer go to IDLE (s_tready=1 the following cycle). No combinational path from m_tready to s_tready.
- Latency, s-transfer cycle → first m_tvalid cycle:
  - trivial or error jobs: 2 cycles;
  - otherwise: 2 + nbits(e)·(WIDTH+1) cycles, where nbits is the index of the highest set bit plus 1.
  - Early termination: leading zero exponent bits cost nothing.
- Arithmetic:
  - all residues < modulus;
  - multiplier internals WIDTH+2 bits wide to avoid overflow of 2·acc + a;
  - no requirement that modulus be odd or prime.
- Simultaneous s_tvalid during a busy period: ignored (s_tready=0); upstream holds data per AXI-stream rules.

Decomposition:
- Shared package modexp_pkg: state encoding enum (IDLE, LOAD, RUN, WAIT, OUT) and localparam MUL_LAT = WIDTH.
- Sub-module mod_mul_serial, instantiated twice; same WIDTH parameter.
  - Ports: clk, rst, start, a, b, m, done, p.
  - Algorithm: MSB-first interleaved multiply; one bit of b per cycle; acc = 2·acc + (b_i ? a : 0), followed by up to two conditional subtractions of m.
  - done is a 1-cycle pulse exactly WIDTH cycles after start; p is held until the next start.
  - start while busy restarts the operation.

Test Plan:
- WIDTH=16: base=4, exp=13, mod=497 → m_tdata=445, terr=0; m_tvalid exactly 2+4·17=70 cycles after accept; m_tid echoes the input tag.
- exp=0, base=3, mod=7 → result 1 after 2 cycles; mod=1, base=0, exp=5 → result 0, terr=0.
- base=10, mod=7 → terr=1, m_tdata=0; mod=0 → terr=1, m_tdata=0; both after 2 cycles.
- Back-to-back jobs (2^10 mod 1000=24, then 7^560 mod 561=1) with m_tready held low for 20 cycles on each → outputs stable while stalled, s_tready=0 until each output transfers, IDs in order.
- Assert rst mid-WAIT of a 64-bit job (WIDTH=64, random operands) → m_tvalid=0 immediately; next job gives the golden-model result with correct latency.
- Random regression, 1000 jobs with WIDTH=64, EXP_WIDTH=64, random stalls on both interfaces → every result matches a software pow(b,e,m) reference.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM state
// encoding and the multiplier latency helper.
package modexp_pkg;

    // Engine control states (one job in flight at a time).
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4
    } state_e;

    // Bit-serial multiplier latency: one cycle per multiplier bit.
    function automatic int mul_lat(input int width);
        return width;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m.
// MSB-first over b. The first bit is consumed on the start edge, so the
// done pulse lands exactly MUL_LAT cycles after the start cycle.
// Requires a < m and m >= 2. p holds its value until the next start.
module mod_mul_serial
    import modexp_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int MUL_LAT = mul_lat(WIDTH);
    localparam int CW      = $clog2(MUL_LAT + 1);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0] step_a_s;
    logic [WIDTH-1:0] step_m_s;
    logic             step_bit_s;
    logic [WIDTH-1:0] next_acc_s;

    // One interleaved step: 2*acc + (bit ? a : 0), then at most two
    // subtractions of m (the sum is below 3m). WIDTH+2 bits avoid overflow.
    function automatic logic [WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] acc_i,
        input logic             bit_i,
        input logic [WIDTH-1:0] a_i,
        input logic [WIDTH-1:0] m_i
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] mw;
        mw = {2'b00, m_i};
        t  = {1'b0, acc_i, 1'b0} + (bit_i ? {2'b00, a_i} : {(WIDTH+2){1'b0}});
        t  = (t >= mw) ? (t - mw) : t;
        t  = (t >= mw) ? (t - mw) : t;
        return t[WIDTH-1:0];
    endfunction

    // Select step operands: fresh inputs on start, latched state otherwise.
    always_comb begin
        step_acc_s = acc_r;
        step_a_s   = a_r;
        step_m_s   = m_r;
        step_bit_s = b_r[WIDTH-1];
        if (start) begin
            step_acc_s = {WIDTH{1'b0}};
            step_a_s   = a;
            step_m_s   = m;
            step_bit_s = b[WIDTH-1];
        end else begin
            step_acc_s = acc_r;
        end
        next_acc_s = mul_step(step_acc_s, step_bit_s, step_a_s, step_m_s);
    end

    // Multiplier iteration state; start always (re)launches an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= {WIDTH{1'b0}};
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            m_r    <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            m_r    <= m;
            b_r    <= b << 1;
            acc_r  <= next_acc_s;
            cnt_r  <= CW'(MUL_LAT - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            acc_r <= next_acc_s;
            b_r   <= b_r << 1;
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign p    = acc_r;

endmodule

// File: rtl/modexp_engine.sv
// Modular exponentiator: base^exp mod modulus, right-to-left
// square-and-multiply with two parallel bit-serial multipliers.
// AXI-stream job in, result with error flag and tag out.
module modexp_engine
    import modexp_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64,
    parameter int ID_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     s_tdata_base,
    input  logic [EXP_WIDTH-1:0] s_tdata_exp,
    input  logic [WIDTH-1:0]     s_tdata_mod,
    input  logic [ID_WIDTH-1:0]  s_tid,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [WIDTH-1:0]     m_tdata,
    output logic [ID_WIDTH-1:0]  m_tid,
    output logic                 m_terr,
    output logic                 m_tvalid,
    input  logic                 m_tready
);

    state_e state_r;
    state_e state_nxt_s;

    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     mod_r;
    logic [WIDTH-1:0]     acc_r;
    logic [EXP_WIDTH-1:0] e_r;
    logic [ID_WIDTH-1:0]  id_r;

    logic                 s_tready_r;
    logic                 m_tvalid_r;
    logic [WIDTH-1:0]     m_tdata_r;
    logic [ID_WIDTH-1:0]  m_tid_r;
    logic                 m_terr_r;

    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic                 op_err_s;
    logic                 mod_one_s;
    logic                 exp_zero_s;
    logic                 exp_last_s;
    logic                 trivial_s;
    logic                 mul_start_s;
    logic                 done_a_s;
    logic                 done_b_s;
    logic                 mul_done_s;
    logic [WIDTH-1:0]     pa_s;
    logic [WIDTH-1:0]     pb_s;
    logic                 res_load_s;
    logic [WIDTH-1:0]     res_data_s;
    logic                 res_err_s;

    assign in_xfer_s  = s_tvalid & s_tready_r;
    assign out_xfer_s = m_tvalid_r & m_tready;
    assign op_err_s   = (mod_r == {WIDTH{1'b0}}) | (b_r >= mod_r);
    assign mod_one_s  = (mod_r == {{(WIDTH-1){1'b0}}, 1'b1});
    assign exp_zero_s = (e_r == {EXP_WIDTH{1'b0}});
    assign exp_last_s = ((e_r >> 1) == {EXP_WIDTH{1'b0}});
    assign trivial_s  = op_err_s | mod_one_s | exp_zero_s;
    assign mul_done_s = done_a_s & done_b_s;

    // acc * b mod m (conditional multiply step)
    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_a (
        .clk(clk), .rst(rst), .start(mul_start_s),
        .a(acc_r), .b(b_r), .m(mod_r), .done(done_a_s), .p(pa_s)
    );

    // b * b mod m (squaring step)
    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_b (
        .clk(clk), .rst(rst), .start(mul_start_s),
        .a(b_r), .b(b_r), .m(mod_r), .done(done_b_s), .p(pb_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: state_nxt_s = in_xfer_s ? LOAD : IDLE;
            LOAD: state_nxt_s = trivial_s ? OUT : RUN;
            RUN:  state_nxt_s = WAIT;
            WAIT: begin
                if (mul_done_s) begin
                    state_nxt_s = exp_last_s ? OUT : RUN;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            OUT:  state_nxt_s = out_xfer_s ? IDLE : OUT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: multiplier launch and result capture strobes.
    always_comb begin
        mul_start_s = 1'b0;
        res_load_s  = 1'b0;
        res_data_s  = {WIDTH{1'b0}};
        res_err_s   = 1'b0;
        case (state_r)
            LOAD: begin
                if (op_err_s) begin
                    res_load_s = 1'b1;
                    res_err_s  = 1'b1;
                end else if (mod_one_s) begin
                    res_load_s = 1'b1;
                end else if (exp_zero_s) begin
                    res_load_s = 1'b1;
                    res_data_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    res_load_s = 1'b0;
                end
            end
            RUN: mul_start_s = 1'b1;
            WAIT: begin
                if (mul_done_s && exp_last_s) begin
                    res_load_s = 1'b1;
                    res_data_s = e_r[0] ? pa_s : acc_r;
                end else begin
                    res_load_s = 1'b0;
                end
            end
            default: mul_start_s = 1'b0;
        endcase
    end

    // Exponentiation working registers: operand capture and per-bit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_r   <= {WIDTH{1'b0}};
            mod_r <= {WIDTH{1'b0}};
            acc_r <= {WIDTH{1'b0}};
            e_r   <= {EXP_WIDTH{1'b0}};
            id_r  <= {ID_WIDTH{1'b0}};
        end else if (in_xfer_s) begin
            b_r   <= s_tdata_base;
            mod_r <= s_tdata_mod;
            e_r   <= s_tdata_exp;
            id_r  <= s_tid;
        end else if (state_r == LOAD) begin
            acc_r <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if ((state_r == WAIT) && mul_done_s) begin
            if (e_r[0]) begin
                acc_r <= pa_s;
            end
            b_r <= pb_s;
            e_r <= e_r >> 1;
        end
    end

    // Registered interface outputs; result fields held while stalled in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_tready_r <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= {WIDTH{1'b0}};
            m_tid_r    <= {ID_WIDTH{1'b0}};
            m_terr_r   <= 1'b0;
        end else begin
            s_tready_r <= (state_nxt_s == IDLE);
            m_tvalid_r <= (state_nxt_s == OUT);
            if (res_load_s) begin
                m_tdata_r <= res_data_s;
                m_terr_r  <= res_err_s;
                m_tid_r   <= id_r;
            end
        end
    end

    assign s_tready = s_tready_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tid    = m_tid_r;
    assign m_terr   = m_terr_r;

endmodule

// File: tb/tb_modexp_engine.sv
// Directed bench for modexp_engine at WIDTH=16: latency, results, stalls,
// error/trivial classification and mid-job reset.
module tb_modexp_engine;

    localparam int W  = 16;
    localparam int EW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_tdata_base = '0;
    logic [EW-1:0] s_tdata_exp  = '0;
    logic [W-1:0]  s_tdata_mod  = '0;
    logic [IW-1:0] s_tid        = '0;
    logic          s_tvalid     = 1'b0;
    logic          s_tready;
    logic [W-1:0]  m_tdata;
    logic [IW-1:0] m_tid;
    logic          m_terr;
    logic          m_tvalid;
    logic          m_tready = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = 0;

    modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata_base(s_tdata_base), .s_tdata_exp(s_tdata_exp),
        .s_tdata_mod(s_tdata_mod), .s_tid(s_tid),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tid(m_tid), .m_terr(m_terr),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference modular power (16-bit operands, 64-bit intermediates).
    function automatic longint ref_pow(input longint b, input longint e, input longint m);
        longint r, x, k;
        r = 1 % m;
        x = b % m;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int nbits(input int e);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
        return n;
    endfunction

    // Present a job and wait (bounded) for it to be accepted.
    task automatic send_job(input string tag, input logic [W-1:0] b, input logic [EW-1:0] e,
                            input logic [W-1:0] m, input logic [IW-1:0] id);
        int n;
        s_tdata_base = b;
        s_tdata_exp  = e;
        s_tdata_mod  = m;
        s_tid        = id;
        s_tvalid     = 1'b1;
        n = 0;
        while (!s_tready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept"}, 64'(s_tready), 64'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    // Wait for a result, check it, stall downstream, then take it.
    task automatic wait_result(input string tag, input logic [W-1:0] exp_data, input logic exp_err,
                               input logic [IW-1:0] exp_id, input int exp_lat, input int stall);
        int n;
        n = 0;
        while (!m_tvalid && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, 64'(m_tvalid), 64'd1);
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
        check({tag, "_data"}, 64'(m_tdata), 64'(exp_data));
        check({tag, "_err"}, 64'(m_terr), 64'(exp_err));
        check({tag, "_id"}, 64'(m_tid), 64'(exp_id));
        check({tag, "_busy_sready"}, 64'(s_tready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, 64'(m_tvalid), 64'd1);
            check({tag, "_stall_data"}, 64'(m_tdata), 64'(exp_data));
            check({tag, "_stall_id"}, 64'(m_tid), 64'(exp_id));
            check({tag, "_stall_sready"}, 64'(s_tready), 64'd0);
        end
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        check({tag, "_drop_valid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_idle_sready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        longint rb, re, rm;
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready", 64'(s_tready), 64'd0);
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_mdata", 64'(m_tdata), 64'd0);
        check("rst_mtid", 64'(m_tid), 64'd0);
        check("rst_mterr", 64'(m_terr), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Main vector: 4^13 mod 497 = 445, 4 exponent bits
        send_job("v445", 16'd4, 16'd13, 16'd497, 4'd3);
        wait_result("v445", 16'd445, 1'b0, 4'd3, 70, 0);

        // Trivial and error classification, 2-cycle latency
        send_job("exp0", 16'd3, 16'd0, 16'd7, 4'd4);
        wait_result("exp0", 16'd1, 1'b0, 4'd4, 2, 0);
        send_job("mod1", 16'd0, 16'd5, 16'd1, 4'd5);
        wait_result("mod1", 16'd0, 1'b0, 4'd5, 2, 0);
        send_job("b_ge_m", 16'd10, 16'd3, 16'd7, 4'd6);
        wait_result("b_ge_m", 16'd0, 1'b1, 4'd6, 2, 0);
        send_job("mod0", 16'd0, 16'd3, 16'd0, 4'd7);
        wait_result("mod0", 16'd0, 1'b1, 4'd7, 2, 0);

        // Boundary residues: (m-1)^2 = 1, (m-1)^3 = m-1, exponent 1
        send_job("neg_sq", 16'd496, 16'd2, 16'd497, 4'd8);
        wait_result("neg_sq", 16'd1, 1'b0, 4'd8, 2 + 2 * 17, 0);
        send_job("neg_cube", 16'd65534, 16'd3, 16'd65535, 4'd9);
        wait_result("neg_cube", 16'd65534, 1'b0, 4'd9, 2 + 2 * 17, 0);
        send_job("exp1", 16'd123, 16'd1, 16'd1000, 4'd10);
        wait_result("exp1", 16'd123, 1'b0, 4'd10, 2 + 17, 0);

        // Back-to-back jobs; the second is held by upstream while the first stalls
        send_job("bb1", 16'd2, 16'd10, 16'd1000, 4'd1);
        s_tdata_base = 16'd7;
        s_tdata_exp  = 16'd560;
        s_tdata_mod  = 16'd561;
        s_tid        = 4'd2;
        s_tvalid     = 1'b1;
        wait_result("bb1", 16'd24, 1'b0, 4'd1, 70, 20);
        send_job("bb2", 16'd7, 16'd560, 16'd561, 4'd2);
        wait_result("bb2", 16'd1, 1'b0, 4'd2, 2 + 10 * 17, 20);

        // Reset in the middle of a multiply; the job must vanish
        send_job("midrst", 16'd7, 16'd560, 16'd561, 4'd11);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("midrst_pre_valid", 64'(m_tvalid), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(m_tvalid), 64'd0);
        check("midrst_sready", 64'(s_tready), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_post_valid", 64'(m_tvalid), 64'd0);
        send_job("after_rst", 16'd4, 16'd13, 16'd497, 4'd12);
        wait_result("after_rst", 16'd445, 1'b0, 4'd12, 70, 0);

        // Short random regression against the reference power function
        for (int j = 0; j < 8; j++) begin
            rm  = longint'($urandom_range(2, 65535));
            rb  = longint'($urandom_range(0, 32'(rm - 1)));
            re  = longint'($urandom_range(1, 65535));
            lat = 2 + nbits(int'(re)) * 17;
            send_job("rnd", 16'(rb), 16'(re), 16'(rm), 4'(j));
            wait_result("rnd", 16'(ref_pow(rb, re, rm)), 1'b0, 4'(j), lat,
                        int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
